ibex_multdiv_issue: RTL and testbench

Front-end and sequencer that sits directly upstream of ibex_multdiv_slow.
- Accepts one MUL/DIV request per transaction over a valid/ready interface and holds its operands stable.
- Drives the enable, select and operand inputs of the slow unit.
- Owns the two 34-bit intermediate-value registers and the shared 33-bit adder that the slow unit uses.
- Captures the result into an output register and presents it to writeback over a second valid/ready interface.

---
 rtl/ibex_multdiv_pkg.sv | 27 ++
 rtl/ibex_multdiv_issue_if.sv | 32 +++
 rtl/ibex_multdiv_adder.sv | 20 ++
 rtl/ibex_multdiv_issue.sv | 156 +++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_multdiv_pkg.sv
// Shared types and constants for the MUL/DIV issue front-end and ibex_multdiv_slow.
//   md_op_e    : operator encoding carried on req_op_i / operator_o
//   md_issue_e : sequencer states of ibex_multdiv_issue
//   IMD_W/OP_W : intermediate-register and operand widths
package ibex_multdiv_pkg;

  localparam int unsigned IMD_W = 34;
  localparam int unsigned OP_W  = 32;

  typedef enum logic [2:0] {
    MD_OP_MULL = 3'd0,
    MD_OP_MULH = 3'd1,
    MD_OP_DIV  = 3'd2,
    MD_OP_REM  = 3'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_issue_e;

  function automatic logic is_mult_op(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_issue_if.sv
// Request and writeback handshakes of ibex_multdiv_issue.
//   master : requester / writeback side (drives req_*_i and wb_ready_i)
//   slave  : the issue unit (drives req_ready_o and wb_*_o)
interface ibex_multdiv_issue_if;
  import ibex_multdiv_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  md_op_e          req_op_i;
  logic [1:0]      req_signed_mode_i;
  logic [OP_W-1:0] req_op_a_i;
  logic [OP_W-1:0] req_op_b_i;
  logic [4:0]      req_rd_i;

  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [OP_W-1:0] wb_data_o;
  logic [4:0]      wb_rd_o;

  modport master (
    output req_valid_i, req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_rd_i,
    output wb_ready_i,
    input  req_ready_o, wb_valid_o, wb_data_o, wb_rd_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_rd_i,
    input  wb_ready_i,
    output req_ready_o, wb_valid_o, wb_data_o, wb_rd_o
  );

endinterface

// File: rtl/ibex_multdiv_adder.sv
// Shared 33-bit adder with carry and zero detect.
//   operand_a_i/operand_b_i : 33-bit addends (bit 0 is the carry-in slot)
//   adder_ext_o             : 34-bit sum including carry out
//   adder_o                 : sum bits [32:1]
//   equal_to_zero_o         : adder_o == 0
module ibex_multdiv_adder
  import ibex_multdiv_pkg::*;
(
  input  logic [32:0]       operand_a_i,
  input  logic [32:0]       operand_b_i,
  output logic [IMD_W-1:0]  adder_ext_o,
  output logic [OP_W-1:0]   adder_o,
  output logic              equal_to_zero_o
);

  assign adder_ext_o     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
  assign adder_o         = adder_ext_o[32:1];
  assign equal_to_zero_o = (adder_o == '0);

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue front-end / sequencer for ibex_multdiv_slow.
//   clk, rst_n            : clock, asynchronous active-low reset
//   md_if (slave)         : request valid/ready + writeback valid/ready
//   flush_i               : kill in-flight request or pending result
//   mult_*/div_*, operator_o, signed_mode_o, op_a_o, op_b_o : slow-unit controls
//   alu_*                 : shared adder used by the slow unit
//   imd_val_*             : the two 34-bit intermediate registers
//   valid_i, multdiv_result_i : slow-unit completion
module ibex_multdiv_issue
  import ibex_multdiv_pkg::*;
#(
  parameter bit DataIndTiming = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ibex_multdiv_issue_if.slave  md_if,
  input  logic                 flush_i,
  output logic                 mult_en_o,
  output logic                 div_en_o,
  output logic                 mult_sel_o,
  output logic                 div_sel_o,
  output md_op_e               operator_o,
  output logic [1:0]           signed_mode_o,
  output logic [OP_W-1:0]      op_a_o,
  output logic [OP_W-1:0]      op_b_o,
  output logic                 data_ind_timing_o,
  output logic                 multdiv_ready_id_o,
  input  logic [32:0]          alu_operand_a_i,
  input  logic [32:0]          alu_operand_b_i,
  output logic [IMD_W-1:0]     alu_adder_ext_o,
  output logic [OP_W-1:0]      alu_adder_o,
  output logic                 equal_to_zero_o,
  input  logic [IMD_W-1:0]     imd_val_d_i [2],
  input  logic [1:0]           imd_val_we_i,
  output logic [IMD_W-1:0]     imd_val_q_o [2],
  input  logic                 valid_i,
  input  logic [OP_W-1:0]      multdiv_result_i
);

  md_issue_e       state_q, state_d;
  logic            kill_q, kill_d;
  md_op_e          op_q, op_d;
  logic [1:0]      sm_q, sm_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [4:0]      rd_q, rd_d;
  logic [IMD_W-1:0] imd_q [2];
  logic [IMD_W-1:0] imd_d [2];

  logic req_ready, wb_valid, busy_mult, busy_div;

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    op_d      = op_q;
    sm_d      = sm_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    data_d    = data_q;
    req_ready = 1'b0;
    wb_valid  = 1'b0;
    busy_mult = 1'b0;
    busy_div  = 1'b0;
    multdiv_ready_id_o = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        req_ready = 1'b1;
        if (md_if.req_valid_i) begin
          op_d    = md_if.req_op_i;
          sm_d    = md_if.req_signed_mode_i;
          a_d     = md_if.req_op_a_i;
          b_d     = md_if.req_op_b_i;
          rd_d    = md_if.req_rd_i;
          kill_d  = 1'b0;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        multdiv_ready_id_o = 1'b1;
        busy_mult = is_mult_op(op_q);
        busy_div  = ~is_mult_op(op_q);
        // Enables stay up after a flush so the slow unit runs back to idle;
        // its result is then discarded.
        if (flush_i) kill_d = 1'b1;
        if (valid_i) begin
          if (kill_q || flush_i) begin
            state_d = MD_IDLE;
          end else begin
            data_d  = multdiv_result_i;
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        wb_valid = 1'b1;
        if (md_if.wb_ready_i || flush_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      imd_d[k] = imd_val_we_i[k] ? imd_val_d_i[k] : imd_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      kill_q  <= 1'b0;
      op_q    <= MD_OP_MULL;
      sm_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      for (int unsigned k = 0; k < 2; k++) imd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      op_q    <= op_d;
      sm_q    <= sm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      for (int unsigned k = 0; k < 2; k++) imd_q[k] <= imd_d[k];
    end
  end

  assign md_if.req_ready_o = req_ready;
  assign md_if.wb_valid_o  = wb_valid;
  assign md_if.wb_data_o   = data_q;
  assign md_if.wb_rd_o     = rd_q;

  assign mult_en_o         = busy_mult;
  assign mult_sel_o        = busy_mult;
  assign div_en_o          = busy_div;
  assign div_sel_o         = busy_div;
  assign operator_o        = op_q;
  assign signed_mode_o     = sm_q;
  assign op_a_o            = a_q;
  assign op_b_o            = b_q;
  assign data_ind_timing_o = DataIndTiming;
  assign imd_val_q_o       = imd_q;

  ibex_multdiv_adder u_adder (
    .operand_a_i     (alu_operand_a_i),
    .operand_b_i     (alu_operand_b_i),
    .adder_ext_o     (alu_adder_ext_o),
    .adder_o         (alu_adder_o),
    .equal_to_zero_o (equal_to_zero_o)
  );

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Self-checking bench for ibex_multdiv_issue: transaction-level reference model,
// a slow-unit stand-in, per-cycle comparison and directed literal checks.
module tb_ibex_multdiv_issue;
  import ibex_multdiv_pkg::*;

  localparam int STUB_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_multdiv_issue_if ifc ();

  logic            flush_i = 1'b0;
  logic            mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  md_op_e          operator_o;
  logic [1:0]      signed_mode_o;
  logic [31:0]     op_a_o, op_b_o;
  logic            data_ind_timing_o, multdiv_ready_id_o;
  logic [32:0]     alu_a = '0, alu_b = '0;
  logic [33:0]     alu_adder_ext_o;
  logic [31:0]     alu_adder_o;
  logic            equal_to_zero_o;
  logic [33:0]     imd_d [2];
  logic [1:0]      imd_we = '0;
  logic [33:0]     imd_q [2];
  logic            valid_i = 1'b0;
  logic [31:0]     result_i = '0;

  ibex_multdiv_issue #(.DataIndTiming(1'b0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .md_if              (ifc),
    .flush_i            (flush_i),
    .mult_en_o          (mult_en_o),
    .div_en_o           (div_en_o),
    .mult_sel_o         (mult_sel_o),
    .div_sel_o          (div_sel_o),
    .operator_o         (operator_o),
    .signed_mode_o      (signed_mode_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .data_ind_timing_o  (data_ind_timing_o),
    .multdiv_ready_id_o (multdiv_ready_id_o),
    .alu_operand_a_i    (alu_a),
    .alu_operand_b_i    (alu_b),
    .alu_adder_ext_o    (alu_adder_ext_o),
    .alu_adder_o        (alu_adder_o),
    .equal_to_zero_o    (equal_to_zero_o),
    .imd_val_d_i        (imd_d),
    .imd_val_we_i       (imd_we),
    .imd_val_q_o        (imd_q),
    .valid_i            (valid_i),
    .multdiv_result_i   (result_i)
  );

  int checks = 0;
  int failures = 0;
  logic run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of a MUL/DIV operation.
  function automatic logic [31:0] calc(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    logic [31:0] r;
    sa = sm[0] ? longint'(signed'(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'(signed'(b)) : longint'({32'd0, b});
    case (op)
      MD_OP_MULL: begin p = sa * sb; r = p[31:0];  end
      MD_OP_MULH: begin p = sa * sb; r = p[63:32]; end
      MD_OP_DIV:  begin if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end end
      default:    begin if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end end
    endcase
    return r;
  endfunction

  // Reference model: one transaction either working in the slow unit or waiting for writeback.
  logic        m_working, m_waiting, m_killed;
  md_op_e      m_op;
  logic [1:0]  m_sm;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_rd;
  logic [33:0] m_imd [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_working <= 1'b0; m_waiting <= 1'b0; m_killed <= 1'b0;
      m_imd[0] <= '0; m_imd[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) if (imd_we[k]) m_imd[k] <= imd_d[k];
      if (!m_working && !m_waiting) begin
        if (ifc.req_valid_i) begin
          m_working <= 1'b1; m_killed <= 1'b0;
          m_op <= ifc.req_op_i; m_sm <= ifc.req_signed_mode_i;
          m_a <= ifc.req_op_a_i; m_b <= ifc.req_op_b_i; m_rd <= ifc.req_rd_i;
          m_res <= calc(ifc.req_op_i, ifc.req_signed_mode_i, ifc.req_op_a_i, ifc.req_op_b_i);
        end
      end else if (m_working) begin
        if (flush_i) m_killed <= 1'b1;
        if (valid_i) begin
          m_working <= 1'b0;
          m_waiting <= !(m_killed || flush_i);
        end
      end else if (ifc.wb_ready_i || flush_i) begin
        m_waiting <= 1'b0;
      end
    end
  end

  // Slow-unit stand-in: answers STUB_LAT enabled cycles after it first sees an enable.
  int stub_cnt = 0;
  always @(posedge clk) begin
    #1;
    valid_i = 1'b0;
    if (!rst_n) stub_cnt = 0;
    else if (mult_en_o || div_en_o) begin
      stub_cnt++;
      if (stub_cnt == STUB_LAT) begin
        valid_i  = 1'b1;
        result_i = calc(operator_o, signed_mode_o, op_a_o, op_b_o);
        stub_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      logic [33:0] e;
      logic        ismul;
      ismul = (m_op == MD_OP_MULL) || (m_op == MD_OP_MULH);
      chk("req_ready", 64'(ifc.req_ready_o), 64'(!m_working && !m_waiting));
      chk("wb_valid", 64'(ifc.wb_valid_o), 64'(m_waiting));
      if (m_waiting) begin
        chk("wb_data", 64'(ifc.wb_data_o), 64'(m_res));
        chk("wb_rd", 64'(ifc.wb_rd_o), 64'(m_rd));
      end
      chk("mult_en", 64'(mult_en_o), 64'(m_working && ismul));
      chk("mult_sel", 64'(mult_sel_o), 64'(m_working && ismul));
      chk("div_en", 64'(div_en_o), 64'(m_working && !ismul));
      chk("div_sel", 64'(div_sel_o), 64'(m_working && !ismul));
      chk("ready_id", 64'(multdiv_ready_id_o), 64'(m_working));
      if (m_working) begin
        chk("operator", 64'(operator_o), 64'(m_op));
        chk("signed_mode", 64'(signed_mode_o), 64'(m_sm));
        chk("op_a", 64'(op_a_o), 64'(m_a));
        chk("op_b", 64'(op_b_o), 64'(m_b));
      end
      e = {1'b0, alu_a} + {1'b0, alu_b};
      chk("adder_ext", 64'(alu_adder_ext_o), 64'(e));
      chk("adder", 64'(alu_adder_o), 64'(e[32:1]));
      chk("eq_zero", 64'(equal_to_zero_o), 64'(e[32:1] == 32'd0));
      chk("imd0", 64'(imd_q[0]), 64'(m_imd[0]));
      chk("imd1", 64'(imd_q[1]), 64'(m_imd[1]));
      chk("data_ind", 64'(data_ind_timing_o), 64'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(ifc.req_ready_o), 64'd1);
    chk({tag, "_wb_valid"}, 64'(ifc.wb_valid_o), 64'd0);
    chk({tag, "_wb_data"}, 64'(ifc.wb_data_o), 64'd0);
    chk({tag, "_wb_rd"}, 64'(ifc.wb_rd_o), 64'd0);
    chk({tag, "_enables"}, 64'({mult_en_o, div_en_o, mult_sel_o, div_sel_o}), 64'd0);
    chk({tag, "_operator"}, 64'(operator_o), 64'd0);
    chk({tag, "_signed"}, 64'(signed_mode_o), 64'd0);
    chk({tag, "_op_a"}, 64'(op_a_o), 64'd0);
    chk({tag, "_op_b"}, 64'(op_b_o), 64'd0);
    chk({tag, "_ready_id"}, 64'(multdiv_ready_id_o), 64'd0);
    chk({tag, "_imd0"}, 64'(imd_q[0]), 64'd0);
    chk({tag, "_imd1"}, 64'(imd_q[1]), 64'd0);
  endtask

  // Presents a request until accepted; returns the number of cycles it waited.
  task automatic issue(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, output int waited);
    logic rdy, ok;
    ifc.req_valid_i = 1'b1; ifc.req_op_i = op; ifc.req_signed_mode_i = sm;
    ifc.req_op_a_i = a; ifc.req_op_b_i = b; ifc.req_rd_i = rd;
    alu_a = {b, 1'b1};  // {b,1} + all-ones yields b in [32:1]: zero test of the divisor
    alu_b = '1;
    waited = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); rdy = ifc.req_ready_o;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
      waited++;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    // Scramble the request bus so holding relies on the latched copy.
    ifc.req_valid_i = 1'b0;
    ifc.req_op_i = md_op_e'(3'($urandom_range(0, 3)));
    ifc.req_signed_mode_i = 2'($urandom);
    ifc.req_op_a_i = $urandom; ifc.req_op_b_i = $urandom; ifc.req_rd_i = 5'($urandom);
  endtask

  task automatic wait_result(input string nm, input logic [31:0] exp, input logic [4:0] rd,
                             input int hold);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.wb_valid_o) begin seen = 1'b1; break; end
    end
    chk({nm, "_seen"}, 64'(seen), 64'd1);
    chk({nm, "_data"}, 64'(ifc.wb_data_o), 64'(exp));
    chk({nm, "_rd"}, 64'(ifc.wb_rd_o), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(ifc.wb_valid_o), 64'd1);
      chk({nm, "_hold_data"}, 64'(ifc.wb_data_o), 64'(exp));
      chk({nm, "_hold_rd"}, 64'(ifc.wb_rd_o), 64'(rd));
      chk({nm, "_hold_ready"}, 64'(ifc.req_ready_o), 64'd0);
    end
    @(posedge clk); #1; ifc.wb_ready_i = 1'b1;
    @(posedge clk); #1; ifc.wb_ready_i = 1'b0;
  endtask

  task automatic imd_write(input int k, input logic [33:0] v);
    imd_we[k] = 1'b1; imd_d[k] = v;
    @(posedge clk); #1;
    imd_we = '0;
  endtask

  initial begin
    int w, wb_seen;
    logic rdy;
    ifc.req_valid_i = 1'b0; ifc.req_op_i = MD_OP_MULL; ifc.req_signed_mode_i = '0;
    ifc.req_op_a_i = '0; ifc.req_op_b_i = '0; ifc.req_rd_i = '0; ifc.wb_ready_i = 1'b0;
    imd_d[0] = '0; imd_d[1] = '0;

    #2 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1; run_cmp = 1'b1;

    // Adder corner cases, pinned by hand.
    alu_a = 33'h1_FFFF_FFFF; alu_b = 33'h0_0000_0001; #1;
    chk("add_carry_ext", 64'(alu_adder_ext_o), 64'h2_0000_0000);
    chk("add_carry_sum", 64'(alu_adder_o), 64'h0);
    chk("add_carry_z", 64'(equal_to_zero_o), 64'd1);
    alu_a = 33'd2; alu_b = 33'd4; #1;
    chk("add_small_sum", 64'(alu_adder_o), 64'd3);
    chk("add_small_z", 64'(equal_to_zero_o), 64'd0);
    @(posedge clk); #1;

    imd_write(0, 34'h2_DEAD_BEEF);
    imd_write(1, 34'h1_2345_6789);
    @(negedge clk);
    chk("imd0_lit", 64'(imd_q[0]), 64'h2_DEAD_BEEF);
    chk("imd1_lit", 64'(imd_q[1]), 64'h1_2345_6789);
    @(posedge clk); #1;

    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5, w);
    wait_result("mull", 32'h0000_002A, 5'd5, 3);
    issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 5'd6, w);
    wait_result("mulh", 32'hFFFF_FFFF, 5'd6, 0);
    issue(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd7, w);
    wait_result("div_s", 32'hFFFF_FFFD, 5'd7, 0);
    issue(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8, w);
    wait_result("rem_s", 32'hFFFF_FFFF, 5'd8, 0);
    issue(MD_OP_DIV, 2'b00, 32'd55, 32'd0, 5'd9, w);
    @(negedge clk);
    chk("div0_eqz_first_busy", 64'(equal_to_zero_o), 64'd1);
    chk("div0_div_en", 64'(div_en_o), 64'd1);
    wait_result("div0", 32'hFFFF_FFFF, 5'd9, 0);
    issue(MD_OP_REM, 2'b00, 32'd13, 32'd0, 5'd10, w);
    wait_result("rem0", 32'd13, 5'd10, 5);
    // Back-to-back: must be accepted in the first IDLE cycle after the handshake.
    issue(MD_OP_MULL, 2'b00, 32'd1000, 32'd1000, 5'd11, w);
    chk("b2b_wait", 64'(w), 64'd0);
    wait_result("b2b", 32'd1000000, 5'd11, 0);

    // Flush while busy: result is dropped; intermediate registers keep updating.
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd3, 5'd12, w);
    @(posedge clk); #1;
    flush_i = 1'b1; imd_we = 2'b10; imd_d[1] = 34'h3_0000_0001;
    @(posedge clk); #1;
    flush_i = 1'b0; imd_we = '0;
    wb_seen = 0; rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.wb_valid_o) wb_seen++;
      if (ifc.req_ready_o) begin rdy = 1'b1; break; end
    end
    chk("flush_returns_idle", 64'(rdy), 64'd1);
    chk("flush_no_wb", 64'(wb_seen), 64'd0);
    chk("flush_imd1_kept", 64'(imd_q[1]), 64'h3_0000_0001);
    @(posedge clk); #1;
    flush_i = 1'b1;  // ignored while idle
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd3, 5'd13, w);
    flush_i = 1'b0;
    wait_result("after_flush", 32'd9, 5'd13, 0);

    // Asynchronous reset in the middle of a division.
    issue(MD_OP_DIV, 2'b11, 32'd50, 32'd7, 5'd14, w);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, w);
    wait_result("post_rst", 32'hFFFF_FFFE, 5'd15, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
